// File: rtl/cnn_pkg.sv
// Shared types, default widths and saturation helper for the CNN tail.
// Used by fc_layer_seq and fc_mac.
package cnn_pkg;

  localparam int IN_NUM_D   = 48;
  localparam int OUT_NUM_D  = 10;
  localparam int IN_LANES_D = 3;
  localparam int IN_W_D     = 12;
  localparam int W_W_D      = 8;
  localparam int ACC_W_D    = 32;
  localparam int OUT_W_D    = 12;
  localparam int SHIFT_D    = 7;

  typedef enum logic [1:0] {
    FILL,
    CALC,
    EMIT
  } state_t;

  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Single signed multiply-accumulate for the time-multiplexed FC layer.
// load restarts the sum from bias + product.
module fc_mac
  import cnn_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int W_W   = W_W_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [W_W-1:0]   w,
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [W_W-1:0]   bias,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [IN_W+W_W-1:0] prod;

  assign prod = w * x;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      if (load) acc <= ACC_W'(bias) + ACC_W'(prod);
      else      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Time-multiplexed FC layer: lane-parallel fill, one MAC per cycle, streamed out.
// Optional argmax outputs enabled by defining FC_ARGMAX_EN.
module fc_layer_seq
  import cnn_pkg::*;
#(
  parameter int IN_NUM   = IN_NUM_D,
  parameter int OUT_NUM  = OUT_NUM_D,
  parameter int IN_LANES = IN_LANES_D,
  parameter int IN_W     = IN_W_D,
  parameter int W_W      = W_W_D,
  parameter int ACC_W    = ACC_W_D,
  parameter int OUT_W    = OUT_W_D,
  parameter int SHIFT    = SHIFT_D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_LANES*IN_W-1:0]      in_data,
  input  logic [0:IN_NUM*OUT_NUM*W_W-1] w_fc,
  input  logic [0:OUT_NUM*W_W-1]        b_fc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(OUT_NUM)-1:0]    out_idx,
  output logic                          out_last
`ifdef FC_ARGMAX_EN
  ,
  output logic                          class_valid,
  output logic [$clog2(OUT_NUM)-1:0]    class_idx
`endif
);

  localparam int BEATS = IN_NUM / IN_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW    = $clog2(IN_NUM);
  localparam int IW    = $clog2(OUT_NUM);
  localparam int WB    = $clog2(IN_NUM * OUT_NUM * W_W);
  localparam int BB    = $clog2(OUT_NUM * W_W);

  localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);
  localparam logic [KW-1:0] LAST_K = KW'(IN_NUM - 1);
  localparam logic [IW-1:0] LAST_O = IW'(OUT_NUM - 1);

  state_t state, nxt;

  logic [BW-1:0] beat;
  logic [KW-1:0] k;
  logic [IW-1:0] o;

  logic signed [IN_W-1:0]  feat [IN_NUM];
  logic signed [W_W-1:0]   w_sel;
  logic signed [W_W-1:0]   b_sel;
  logic signed [IN_W-1:0]  x_sel;
  logic [WB-1:0]           w_base;
  logic [BB-1:0]           b_base;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;
  logic                    fire;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      FILL: if (in_valid && beat == LAST_B) nxt = CALC;
      CALC: if (k == LAST_K) nxt = EMIT;
      EMIT: if (out_ready) nxt = (o == LAST_O) ? FILL : CALC;
      default: nxt = FILL;
    endcase
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state == EMIT);
  assign fire      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      k    <= '0;
      o    <= '0;
    end else begin
      unique case (state)
        FILL: begin
          k <= '0;
          o <= '0;
          if (in_valid) beat <= (beat == LAST_B) ? '0 : beat + 1'b1;
        end
        CALC: k <= (k == LAST_K) ? '0 : k + 1'b1;
        EMIT: if (fire && o != LAST_O) o <= o + 1'b1;
        default: ;
      endcase
    end
  end

  // Feature buffer carries no reset; its contents are rewritten every vector.
  always_ff @(posedge clk) begin
    if (state == FILL && in_valid) begin
      for (int l = 0; l < IN_LANES; l++)
        feat[KW'(l * BEATS) + KW'(beat)] <= in_data[l*IN_W +: IN_W];
    end
  end

  always_comb begin
    w_base = WB'((int'(o) * IN_NUM + int'(k)) * W_W);
    b_base = BB'(int'(o) * W_W);
    w_sel  = w_fc[w_base +: W_W];
    b_sel  = b_fc[b_base +: W_W];
    x_sel  = feat[k];
  end

  fc_mac #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (state == CALC),
    .load (state == CALC && k == '0),
    .w    (w_sel),
    .x    (x_sel),
    .bias (b_sel),
    .acc  (acc)
  );

  // acc holds through EMIT, so the result is stable under back-pressure.
  assign acc_sh   = acc >>> SHIFT;
  assign out_data = OUT_W'(sat(64'(acc_sh), OUT_W));
  assign out_idx  = o;
  assign out_last = out_valid && (o == LAST_O);

`ifdef FC_ARGMAX_EN
  logic signed [OUT_W-1:0] best;
  logic [IW-1:0]           best_idx;
  logic                    take;

  assign take = (o == '0) || ($signed(out_data) > best);

  always_ff @(posedge clk) begin
    if (rst) begin
      best        <= '0;
      best_idx    <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
    end else begin
      class_valid <= 1'b0;
      if (fire) begin
        if (take) begin
          best     <= $signed(out_data);
          best_idx <= o;
        end
        if (o == LAST_O) begin
          class_valid <= 1'b1;
          class_idx   <= take ? o : best_idx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed self-checking bench for fc_layer_seq (default parameters).
// Argmax scenario compiled in when FC_ARGMAX_EN is defined.
module tb_fc_layer_seq;

  localparam int IN_NUM   = 48;
  localparam int OUT_NUM  = 10;
  localparam int IN_LANES = 3;
  localparam int IN_W     = 12;
  localparam int W_W      = 8;
  localparam int OUT_W    = 12;
  localparam int BEATS    = IN_NUM / IN_LANES;

  logic                          clk;
  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  logic [IN_LANES*IN_W-1:0]      in_data;
  logic [0:IN_NUM*OUT_NUM*W_W-1] w_fc;
  logic [0:OUT_NUM*W_W-1]        b_fc;
  logic                          out_valid;
  logic                          out_ready;
  logic [OUT_W-1:0]              out_data;
  logic [3:0]                    out_idx;
  logic                          out_last;
`ifdef FC_ARGMAX_EN
  logic                          class_valid;
  logic [3:0]                    class_idx;
`endif

  int pass_cnt;
  int total_cnt;

  logic [IN_W-1:0] fin [IN_NUM];
  int got_d [OUT_NUM];
  int got_i [OUT_NUM];
  int got_l [OUT_NUM];
  int lat   [OUT_NUM];

  fc_layer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_fc      (w_fc),
    .b_fc      (b_fc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef FC_ARGMAX_EN
    ,
    .class_valid (class_valid),
    .class_idx   (class_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input int v);
    for (int i = 0; i < IN_NUM; i++) fin[i] = IN_W'(v);
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < IN_NUM * OUT_NUM; i++) w_fc[i*W_W +: W_W] = W_W'(v);
  endtask

  task automatic set_b(input int step);
    for (int o = 0; o < OUT_NUM; o++) b_fc[o*W_W +: W_W] = W_W'(o * step);
  endtask

  // Ends at the negedge just after the final beat is accepted.
  task automatic send_vec();
    for (int b = 0; b < BEATS; b++) begin
      int guard;
      in_valid = 1'b1;
      for (int l = 0; l < IN_LANES; l++)
        in_data[l*IN_W +: IN_W] = fin[l*BEATS + b];
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    out_ready = 1'b1;
    for (int j = 0; j < n; j++) begin
      int cnt;
      cnt = 1;
      while (!out_valid && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      if (!out_valid) begin
        total_cnt++;
        $display("FAIL collect_timeout: output %0d got no out_valid, required out_valid=1", j);
        return;
      end
      got_d[j] = int'($signed(out_data));
      got_i[j] = int'(out_idx);
      got_l[j] = int'(out_last);
      lat[j]   = cnt;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 12'd0) $display("FAIL reset_out_data: got %0d, required 0", out_data);
    else pass_cnt++;
    total_cnt++;
    if (out_idx !== 4'd0) $display("FAIL reset_out_idx: got %0d, required 0", out_idx);
    else pass_cnt++;
    total_cnt++;
    if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b, required 0", out_last);
    else pass_cnt++;
  endtask

  // 48 * 128 = 6144, >>> 7 = 48 for every neuron.
  task automatic test_ones();
    set_in(128);
    set_w(1);
    set_b(0);
    send_vec();
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL ones_in_ready_low: got %b, required 0", in_ready);
    else pass_cnt++;
    collect(OUT_NUM);
    for (int o = 0; o < OUT_NUM; o++) begin
      total_cnt++;
      if (got_d[o] !== 48 || got_i[o] !== o || got_l[o] !== int'(o == OUT_NUM - 1))
        $display("FAIL ones_out%0d: got data=%0d idx=%0d last=%0d, required data=48 idx=%0d last=%0d",
                 o, got_d[o], got_i[o], got_l[o], o, int'(o == OUT_NUM - 1));
      else pass_cnt++;
      total_cnt++;
      if (lat[o] !== 49) $display("FAIL ones_latency%0d: got %0d, required 49", o, lat[o]);
      else pass_cnt++;
    end
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL ones_return_fill: got in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    set_in(2047);
    set_w(127);
    set_b(0);
    send_vec();
    collect(OUT_NUM);
    for (int o = 0; o < OUT_NUM; o++) begin
      total_cnt++;
      if (got_d[o] !== 2047) $display("FAIL sat_pos%0d: got %0d, required 2047", o, got_d[o]);
      else pass_cnt++;
    end
    set_w(-128);
    send_vec();
    collect(OUT_NUM);
    for (int o = 0; o < OUT_NUM; o++) begin
      total_cnt++;
      if (got_d[o] !== -2048) $display("FAIL sat_neg%0d: got %0d, required -2048", o, got_d[o]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bias();
    set_in(1);
    set_w(0);
    set_b(10);
    send_vec();
    collect(OUT_NUM);
    for (int o = 0; o < OUT_NUM; o++) begin
      total_cnt++;
      if (got_d[o] !== 0 || got_i[o] !== o)
        $display("FAIL bias%0d: got data=%0d idx=%0d, required data=0 idx=%0d", o, got_d[o], got_i[o], o);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    set_in(128);
    set_w(1);
    set_b(0);
    send_vec();
    collect(3);
    out_ready = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    for (int c = 0; c < 20; c++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 12'd48 || out_idx !== 4'd3 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b data=%0d idx=%0d in_ready=%b, required 1 48 3 0",
                 c, out_valid, out_data, out_idx, in_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    collect(6);
    total_cnt++;
    if (lat[0] !== 49) $display("FAIL bp_release_latency: got %0d, required 49", lat[0]);
    else pass_cnt++;
    for (int j = 0; j < 6; j++) begin
      total_cnt++;
      if (got_i[j] !== j + 4 || got_d[j] !== 48)
        $display("FAIL bp_after%0d: got idx=%0d data=%0d, required idx=%0d data=48", j, got_i[j], got_d[j], j + 4);
      else pass_cnt++;
    end
  endtask

  // Reset lands on the edge that closes CALC k=20 of neuron 5.
  task automatic test_rst_midcalc();
    set_in(128);
    set_w(1);
    set_b(0);
    send_vec();
    collect(5);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid: got out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    else pass_cnt++;
    set_in(256);
    send_vec();
    collect(OUT_NUM);
    for (int o = 0; o < OUT_NUM; o++) begin
      total_cnt++;
      if (got_d[o] !== 96 || got_i[o] !== o)
        $display("FAIL rst_fresh%0d: got data=%0d idx=%0d, required data=96 idx=%0d", o, got_d[o], got_i[o], o);
      else pass_cnt++;
    end
  endtask

`ifdef FC_ARGMAX_EN
  // Neurons 1 and 2 tie at 96, others 48: lower index wins.
  task automatic test_argmax();
    set_in(128);
    set_w(1);
    set_b(0);
    for (int i = 0; i < IN_NUM; i++) begin
      w_fc[(1*IN_NUM+i)*W_W +: W_W] = 8'd2;
      w_fc[(2*IN_NUM+i)*W_W +: W_W] = 8'd2;
    end
    send_vec();
    collect(OUT_NUM);
    total_cnt++;
    if (class_valid !== 1'b1 || class_idx !== 4'd1)
      $display("FAIL argmax_pulse: got valid=%b idx=%0d, required 1 and 1", class_valid, class_idx);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (class_valid !== 1'b0) $display("FAIL argmax_single: got %b, required 0", class_valid);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    w_fc = '0;
    b_fc = '0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_ones();
    test_saturate();
    test_bias();
    test_backpressure();
    test_rst_midcalc();
`ifdef FC_ARGMAX_EN
    test_argmax();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Parametrised, time-multiplexed fully connected layer for the CNN classifier tail. It collects a flattened feature vector arriving over several parallel lanes and computes each output neuron with a single signed multiply-accumulate per cycle. Results leave over a valid/ready stream with output index and last flag. It replaces the fully combinational dot product with one DSP-sized MAC, adds output back-pressure and saturation, and sits between the final pooling stage and the classifier output.

## Interface
- `IN_NUM`, 48: input vector length; must be a multiple of `IN_LANES`
- `OUT_NUM`, 10: number of output neurons
- `IN_LANES`, 3: features accepted per input beat
- `IN_W`, 12: signed input feature width
- `W_W`, 8: signed weight and bias width
- `ACC_W`, 32: signed accumulator width; must be ≥ `IN_W+W_W+clog2(IN_NUM)+1`
- `OUT_W`, 12: signed output width
- `SHIFT`, 7: arithmetic right shift applied before saturation
- `clk` in 1: clock
- `rst` in 1: synchronous reset, active-high
- `in_valid` in 1: input beat valid
- `in_ready` out 1: high only in FILL
- `in_data` in `IN_LANES*IN_W`: lane l is at `[l*IN_W +: IN_W]`
- `w_fc` in `IN_NUM*OUT_NUM*W_W`, declared `[0:N-1]`: weight (o,i) is at `[(o*IN_NUM+i)*W_W +: W_W]`
- `b_fc` in `OUT_NUM*W_W`, declared `[0:N-1]`: bias o is at `[o*W_W +: W_W]`
- `out_valid` out 1, `out_ready` in 1: result handshake
- `out_data` out `OUT_W`: saturated result
- `out_idx` out `clog2(OUT_NUM)`: neuron index of `out_data`
- `out_last` out 1: high with `out_idx==OUT_NUM-1`

## Operation
- The FSM has three states: FILL, CALC and EMIT. Reset enters FILL with beat count 0 and all outputs 0.
- **FILL**
  - A beat is accepted when `in_valid & in_ready`.
  - Lane l of beat b is written to `buf[l*(IN_NUM/IN_LANES)+b]`.
  - After beat `IN_NUM/IN_LANES-1`, the FSM goes to CALC with o=0 and k=0.
- **CALC**
  - At k=0, acc is loaded with sign-extended `bias[o] + w(o,0)*buf[0]`.
  - At each later k, `acc += w(o,k)*buf[k]`.
  - After k=IN_NUM-1, the FSM goes to EMIT.
  - All products are signed and full-width before extension to `ACC_W`.
- **EMIT**
  - `out_data = sat_OUT_W(acc >>> SHIFT)`.
  - Saturation bounds are `2^(OUT_W-1)-1` and `-2^(OUT_W-1)`.
  - `out_valid=1`.
  - When `out_ready` is high:
    - If o<OUT_NUM-1: o is incremented and the FSM goes to CALC.
    - Otherwise: the FSM goes to FILL.
  - `out_data`, `out_idx` and `out_last` hold stable while `out_valid & !out_ready`.
- Weights and biases are static while out of FILL. Changes during CALC or EMIT give undefined results.
- A reset at any point abandons the vector. The buffer contents are don't-care after reset.

## Timing
- `in_ready` is 1 during FILL, including the cycle after reset is released. It is 0 in the cycle after the final beat is accepted.
- The first `out_valid` rises `IN_NUM+1` cycles after the edge that accepts the final beat.
- Each following output rises `IN_NUM+1` cycles after the previous output is accepted.
- With `out_ready` tied high, one vector takes `IN_NUM/IN_LANES + OUT_NUM*(IN_NUM+1)` cycles.
- `in_ready` returns to 1 in the cycle after the last output is accepted. In that cycle `out_valid` is 0.
- Input and output never overlap. `in_ready` and `out_valid` are never both 1.

## Configuration
- **`FC_ARGMAX_EN` defined**
  - Adds outputs `class_valid` (1 bit) and `class_idx` (`clog2(OUT_NUM)` bits).
  - A running maximum over saturated `out_data` is tracked. Ties keep the lower index.
  - `class_valid` pulses for one cycle on the edge after the `out_last` handshake, with the winning index.
  - Both outputs reset to 0.
- **`FC_ARGMAX_EN` undefined**
  - The ports and logic are absent. Stream behaviour is identical in both cases.

## Structure
- Package `cnn_pkg` holds:
  - the state enum (FILL/CALC/EMIT);
  - the `sat` function;
  - the default width constants.
- Sub-module `fc_mac`:
  - signed `W_W`×`IN_W` multiply;
  - `ACC_W` accumulate;
  - load/accumulate control input.
- The top holds the FSM, buffer, index counters and output register.

## Test plan
1. All inputs 128, all weights 1, bias 0 -> ten outputs of 48, `out_idx` 0..9, `out_last` only on 9.
2. Inputs 2047, weights 127 -> `out_data` 2047 (saturated). Weights -128 -> -2048.
3. Inputs 1, weights 0, biases o*10 (o=0..9) -> `out_data` 0 for every neuron (small sums are shifted out). With `SHIFT=0`, `out_data`=o*10.
4. Hold `out_ready` low for 20 cycles on output 3 -> `out_data`/`out_idx` stable and `in_ready` stays 0. Release -> output 4 follows `IN_NUM+1` cycles later.
5. Assert `rst` at CALC k=20 of neuron 5 -> next cycle `out_valid=0`, `in_ready=1`. A fresh vector then produces correct results from index 0.
6. With `FC_ARGMAX_EN` and `SHIFT=0`, inputs 0, biases {3,9,9,1,...} -> `class_valid` pulse with `class_idx`=1.
